// File: rtl/instr_pkg.sv
// Shared instruction-path types and default sizing for the instruction queue.
package instr_pkg;

  localparam int INSTR_WIDTH   = 64;
  localparam int INSTR_Q_DEPTH = 64;

  typedef logic [INSTR_WIDTH-1:0] instr_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for a power-of-two circular FIFO, plus the
// registered almost-full/almost-empty flags.
module fifo_ptr_ctrl #(
  parameter int DEPTH      = 64,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  out_ready,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [CW-1:0]         count_next;
  logic                  push;
  logic                  pop;

  // Ready/valid come only from registered count, so neither side sees a
  // combinational path from the other.
  assign in_ready  = (count != FULL_LVL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_en   = push & ~flush;
  assign wr_addr = tail;
  assign rd_addr = head;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        // Pointers wrap by natural overflow of the power-of-two width.
        if (push) tail <= tail + ADDR_WIDTH'(1);
        if (pop)  head <= head + ADDR_WIDTH'(1);
      end
      count        <= count_next;
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
    end
  end

endmodule

// File: rtl/instr_queue.sv
// First-word-fall-through instruction FIFO between the external instruction
// interface and the controller; storage here, bookkeeping in fifo_ptr_ctrl.
module instr_queue
  import instr_pkg::*;
#(
  parameter int DATA_WIDTH = INSTR_WIDTH,
  parameter int DEPTH      = INSTR_Q_DEPTH,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Storage is deliberately left unreset; out_data is only meaningful with out_valid.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ptr_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

  assign out_data = mem[rd_addr];

endmodule

// File: tb/tb_instr_queue.sv
// Randomised and directed bench for instr_queue (DEPTH=4) against a queue model.
module tb_instr_queue;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    count;
  logic          almost_full;
  logic          almost_empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q [$];

  instr_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, take the edge, update the model, settle to edge+1.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    bit do_push, do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    do_push = v && (model_q.size() != DEPTH);
    do_pop  = r && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (f) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_q.delete();
    n_checks++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: cnt=%0d ir=%b ov=%b ae=%b af=%b, need 0 1 0 1 0",
               count, in_ready, out_valid, almost_empty, almost_full);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 64'hDEAD, 1'b1, 1'b0);
      n_checks++;
      if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
          almost_empty !== 1'b1 || almost_full !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: cnt=%0d ir=%b ov=%b ae=%b af=%b, need 0 1 0 1 0",
                 i, count, in_ready, out_valid, almost_empty, almost_full);
      end
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 64'hA0 + 64'(i);
      cycle(1'b1, d, 1'b0, 1'b0);
      n_checks++;
      if (count !== 3'(i + 1) || almost_full !== ((i + 1) >= AF) ||
          in_ready !== (i != 3) || out_data !== 64'hA0) begin
        n_fail++;
        $display("FAIL fill[%0d]: cnt=%0d af=%b ir=%b head=%h, need cnt=%0d af=%b ir=%b head=a0",
                 i, count, almost_full, in_ready, out_data, i + 1, (i + 1) >= AF, i != 3);
      end
    end
    cycle(1'b1, 64'hA4, 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_data !== 64'hA0) begin
      n_fail++;
      $display("FAIL fill_overflow: cnt=%0d ir=%b head=%h, need 4 0 a0", count, in_ready, out_data);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hA0 + 64'(i)) begin
        n_fail++;
        $display("FAIL drain[%0d]: ov=%b data=%h, need 1 %h", i, out_valid, out_data, 64'hA0 + 64'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: ov=%b cnt=%0d ae=%b af=%b, need 0 0 1 0",
               out_valid, count, almost_empty, almost_full);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 64'h10, 1'b0, 1'b0);
    cycle(1'b1, 64'h11, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_data !== 64'h10 + 64'(i)) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got %h need %h", i, out_data, 64'h10 + 64'(i));
      end
      cycle(1'b1, 64'h12 + 64'(i), 1'b1, 1'b0);
      n_checks++;
      if (count !== 3'd2 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_count[%0d]: cnt=%0d ov=%b need 2 1", i, count, out_valid);
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_data !== 64'h1A + 64'(i)) begin
        n_fail++;
        $display("FAIL b2b_tail[%0d]: got %h need %h", i, out_data, 64'h1A + 64'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h40 + 64'(i), 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_pre: cnt=%0d need 3", count);
    end
    cycle(1'b1, 64'h43, 1'b1, 1'b1);
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: cnt=%0d ov=%b ae=%b af=%b need 0 0 1 0",
               count, out_valid, almost_empty, almost_full);
    end
    cycle(1'b1, 64'h55, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h55 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_push: ov=%b data=%h cnt=%0d need 1 55 1", out_valid, out_data, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 64'h30, 1'b0, 1'b0);
    cycle(1'b1, 64'h31, 1'b0, 1'b0);
    n_checks++;
    if (count !== 3'd2) begin
      n_fail++;
      $display("FAIL areset_pre: cnt=%0d need 2", count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_now: cnt=%0d ov=%b ir=%b ae=%b need 0 0 1 1",
               count, out_valid, in_ready, almost_empty);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 64'h77, 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h77 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL areset_push: ov=%b data=%h cnt=%0d need 1 77 1", out_valid, out_data, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_pop: ov=%b cnt=%0d need 0 0", out_valid, count);
    end
  endtask

  task automatic test_random();
    logic [2:0] exp_cnt;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
      exp_cnt = 3'(model_q.size());
      n_checks++;
      if (count !== exp_cnt || out_valid !== (model_q.size() != 0) ||
          in_ready !== (model_q.size() != DEPTH) ||
          almost_full !== (model_q.size() >= AF) ||
          almost_empty !== (model_q.size() <= AE)) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: cnt=%0d ov=%b ir=%b af=%b ae=%b, need cnt=%0d",
                 i, count, out_valid, in_ready, almost_full, almost_empty, exp_cnt);
      end
      if (model_q.size() != 0) begin
        n_checks++;
        if (out_data !== model_q[0]) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got %h need %h", i, out_data, model_q[0]);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
